// File: rtl/raster_scan_counter_if.sv
// Pixel-beat stream from the raster scan counter to the iteration engine.
// The producer drives valid, payload and flags; the consumer drives ready.
interface raster_scan_counter_if #(
    parameter int unsigned XW = 9,
    parameter int unsigned YW = 8,
    parameter int unsigned AW = 17
);
    logic          out_valid;
    logic          out_ready;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [AW-1:0] addr;
    logic          sof;
    logic          eol;
    logic          eof;

    modport master (
        output out_valid, x, y, addr, sof, eol, eof,
        input  out_ready
    );

    modport slave (
        input  out_valid, x, y, addr, sof, eol, eof,
        output out_ready
    );
endinterface

// File: rtl/raster_scan_counter.sv
// Raster-order pixel coordinate generator with single/continuous frame modes,
// abort, frame markers and a wrapping completed-frame counter.
module raster_scan_counter #(
    parameter int unsigned H_PIXELS = 320,
    parameter int unsigned V_PIXELS = 240,
    parameter int unsigned XW       = $clog2(H_PIXELS),
    parameter int unsigned YW       = $clog2(V_PIXELS),
    parameter int unsigned AW       = $clog2(H_PIXELS * V_PIXELS),
    parameter int unsigned FRAME_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        continuous,
    raster_scan_counter_if.master       bus,
    output logic                        busy,
    output logic                        frame_done,
    output logic [FRAME_W-1:0]          frame_count
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StScan = 1'b1;

    localparam logic [XW-1:0] XLast = XW'(H_PIXELS - 1);
    localparam logic [YW-1:0] YLast = YW'(V_PIXELS - 1);

    logic [0:0]         state_q, state_d;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [FRAME_W-1:0] frame_count_q, frame_count_d;
    logic               frame_done_q, frame_done_d;

    logic valid;
    logic accept;
    logic last_x;
    logic last_y;

    assign valid  = (state_q == StScan);
    assign accept = valid & bus.out_ready;
    assign last_x = (x_q == XLast);
    assign last_y = (y_q == YLast);

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        addr_d        = addr_q;
        frame_count_d = frame_count_q;
        frame_done_d  = 1'b0;

        // Abort wins over start and over a coincident last-pixel accept.
        if (abort) begin
            state_d = StIdle;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StScan;
                    end
                end
                StScan: begin
                    if (accept) begin
                        if (last_x && last_y) begin
                            x_d           = '0;
                            y_d           = '0;
                            addr_d        = '0;
                            frame_count_d = frame_count_q + FRAME_W'(1);
                            frame_done_d  = 1'b1;
                            state_d       = continuous ? StScan : StIdle;
                        end else if (last_x) begin
                            x_d    = '0;
                            y_d    = y_q + YW'(1);
                            addr_d = addr_q + AW'(1);
                        end else begin
                            x_d    = x_q + XW'(1);
                            addr_d = addr_q + AW'(1);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            x_q           <= '0;
            y_q           <= '0;
            addr_q        <= '0;
            frame_count_q <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            addr_q        <= addr_d;
            frame_count_q <= frame_count_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign bus.out_valid = valid;
    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.addr      = addr_q;
    assign bus.sof       = valid & (x_q == '0) & (y_q == '0);
    assign bus.eol       = valid & last_x;
    assign bus.eof       = valid & last_x & last_y;

    assign busy        = valid;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;

endmodule
